// File: rtl/shift_lr_pkg.sv
// Shared widths, types and helpers for the shift_lr barrel shifter.
package shift_lr_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  // One shift operation as sampled from the inputs.
  typedef struct packed {
    data_t  x;
    shamt_t s;
    logic   left;
    logic   lg;
  } op_t;

  // Mirror a data word so that bit 0 becomes bit DATA_W-1.
  function automatic data_t bit_rev(input data_t d);
    data_t r;
    r = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_lr_stage.sv
// One logarithmic mux level: right shift by DIST with a supplied fill bit when enabled.
module shift_lr_stage
  import shift_lr_pkg::*;
#(
  parameter int unsigned DIST = 1
) (
  input  data_t data_i,
  input  logic  en_i,
  input  logic  fill_i,
  output data_t data_c_o
);

  data_t shifted_c;

  // Vacated upper DIST bits take the fill bit.
  assign shifted_c = {{DIST{fill_i}}, data_i[DATA_W-1:DIST]};

  // Pass through untouched when this amount bit is clear.
  assign data_c_o = en_i ? shifted_c : data_i;

endmodule

// File: rtl/shift_lr.sv
// Registered 32-bit bidirectional barrel shifter (left, logical right, arithmetic right).
// Optional input register: define SHIFT_LR_IN_REG_EN for 2-cycle latency; default is 1 cycle.
module shift_lr
  import shift_lr_pkg::*;
(
  input  logic   CLOCK,
  input  logic   RESET,
  input  data_t  X,
  input  shamt_t S,
  input  logic   LEFT,
  input  logic   LOG,
  output data_t  Z
);

  op_t   op_in_c;
  op_t   op_c;
  logic  fill_c;
  data_t net_in_c;
  data_t st1_c;
  data_t st2_c;
  data_t st4_c;
  data_t st8_c;
  data_t st16_c;
  data_t res_c;
  data_t z_d;
  data_t z_q;

  // Bundle the raw inputs into one operation.
  always_comb begin
    op_in_c      = '0;
    op_in_c.x    = X;
    op_in_c.s    = S;
    op_in_c.left = LEFT;
    op_in_c.lg   = LOG;
  end

`ifdef SHIFT_LR_IN_REG_EN
  op_t op_q;

  // Input capture register; adds one cycle of latency.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      op_q <= '0;
    end else begin
      op_q <= op_in_c;
    end
  end

  assign op_c = op_q;
`else
  assign op_c = op_in_c;
`endif

  // Sign fill only for arithmetic right shifts; left shifts always zero fill.
  assign fill_c = ~op_c.left & ~op_c.lg & op_c.x[DATA_W-1];

  // Left shifts reuse the right-shift network on the mirrored operand.
  assign net_in_c = op_c.left ? bit_rev(op_c.x) : op_c.x;

  shift_lr_stage #(.DIST(1)) u_stage1 (
    .data_i   (net_in_c),
    .en_i     (op_c.s[0]),
    .fill_i   (fill_c),
    .data_c_o (st1_c)
  );

  shift_lr_stage #(.DIST(2)) u_stage2 (
    .data_i   (st1_c),
    .en_i     (op_c.s[1]),
    .fill_i   (fill_c),
    .data_c_o (st2_c)
  );

  shift_lr_stage #(.DIST(4)) u_stage4 (
    .data_i   (st2_c),
    .en_i     (op_c.s[2]),
    .fill_i   (fill_c),
    .data_c_o (st4_c)
  );

  shift_lr_stage #(.DIST(8)) u_stage8 (
    .data_i   (st4_c),
    .en_i     (op_c.s[3]),
    .fill_i   (fill_c),
    .data_c_o (st8_c)
  );

  shift_lr_stage #(.DIST(16)) u_stage16 (
    .data_i   (st8_c),
    .en_i     (op_c.s[4]),
    .fill_i   (fill_c),
    .data_c_o (st16_c)
  );

  // Undo the mirroring for left shifts.
  assign res_c = op_c.left ? bit_rev(st16_c) : st16_c;
  assign z_d   = res_c;

  // Output register; cleared immediately on reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_shift_lr.sv
// Directed and sweep bench for shift_lr; honours SHIFT_LR_IN_REG_EN for latency.
module tb_shift_lr;

`ifdef SHIFT_LR_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLOCK;
  logic        RESET;
  logic [31:0] X;
  logic [4:0]  S;
  logic        LEFT;
  logic        LOG;
  logic [31:0] Z;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  shift_lr dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .X     (X),
    .S     (S),
    .LEFT  (LEFT),
    .LOG   (LOG),
    .Z     (Z)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                            input logic left, input logic lg);
    if (left)    return x << s;
    else if (lg) return x >> s;
    else         return 32'($signed(x) >>> s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: Z=%h expected %h", tag, obs, exp);
  endtask

  // Drive one operation for one cycle; check whichever result is due now.
  task automatic step(input logic [31:0] x, input logic [4:0] s, input logic left,
                      input logic lg, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    X = x; S = s; LEFT = left; LOG = lg;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLOCK);
    #1;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, Z, e);
    end
  endtask

  initial begin
    logic [31:0] rx;
    RESET = 1'b1; X = '0; S = '0; LEFT = 1'b0; LOG = 1'b0;
    #1;
    check("reset_state", Z, 32'h0000_0000);
    @(posedge CLOCK); #1;
    check("reset_hold", Z, 32'h0000_0000);
    #3 RESET = 1'b0;

    // Arithmetic and logical right
    step(32'h8000_0000, 5'd4,  1'b0, 1'b0, 32'hF800_0000, "asr_neg_s4");
    step(32'h7FFF_FFFF, 5'd4,  1'b0, 1'b0, 32'h07FF_FFFF, "asr_pos_s4");
    step(32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'h0800_0000, "lsr_s4");
    step(32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'h0000_0001, "lsr_s31");
    // Left with both LOG values
    step(32'h8000_0001, 5'd1,  1'b1, 1'b0, 32'h0000_0002, "shl_s1_log0");
    step(32'h8000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0002, "shl_s1_log1");
    step(32'h0000_000F, 5'd28, 1'b1, 1'b0, 32'hF000_0000, "shl_s28_log0");
    step(32'h0000_000F, 5'd28, 1'b1, 1'b1, 32'hF000_0000, "shl_s28_log1");
    // S=0 in every mode
    step(32'h8BAD_F00D, 5'd0,  1'b1, 1'b0, 32'h8BAD_F00D, "s0_shl_log0");
    step(32'h8BAD_F00D, 5'd0,  1'b1, 1'b1, 32'h8BAD_F00D, "s0_shl_log1");
    step(32'h8BAD_F00D, 5'd0,  1'b0, 1'b1, 32'h8BAD_F00D, "s0_lsr");
    step(32'h8BAD_F00D, 5'd0,  1'b0, 1'b0, 32'h8BAD_F00D, "s0_asr");
    // S=31 boundaries
    step(32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, "asr_s31_neg");
    step(32'h7FFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0000, "asr_s31_pos");
    step(32'h0000_0003, 5'd31, 1'b1, 1'b0, 32'h8000_0000, "shl_s31");
    // Mode changes every cycle
    step(32'hF000_0001, 5'd4,  1'b1, 1'b0, 32'h0000_0010, "mc_shl");
    step(32'hF000_0001, 5'd4,  1'b0, 1'b1, 32'h0F00_0000, "mc_lsr");
    step(32'hF000_0001, 5'd4,  1'b0, 1'b0, 32'hFF00_0000, "mc_asr");
    step(32'hF000_0001, 5'd4,  1'b1, 1'b1, 32'h0000_0010, "mc_shl_log1");
    step(32'hF000_0001, 5'd4,  1'b0, 1'b0, 32'hFF00_0000, "mc_asr2");

    // Sweep S in each of the four modes with random operands
    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s < 32; s++) begin
        rx = $urandom();
        if (s == 31) rx[31] = m[0];
        step(rx, 5'(s), m[1], m[0], ref_shift(rx, 5'(s), m[1], m[0]),
             $sformatf("sweep_m%0d_s%0d", m, s));
      end
    end
    // Leave a known non-zero result in flight
    step(32'h1234_5678, 5'd4, 1'b1, 1'b0, 32'h2345_6780, "pre_reset");
    for (int i = 1; i < LAT; i++) step(32'h0, 5'd0, 1'b0, 1'b0, 32'h0, "flush");

    // Asynchronous reset between edges
    X = 32'hDEAD_BEEF; S = 5'd3; LEFT = 1'b1; LOG = 1'b0;
    #3 RESET = 1'b1;
    #1 check("rst_async", Z, 32'h0000_0000);
    @(posedge CLOCK); #1;
    check("rst_async_hold", Z, 32'h0000_0000);
    #2 RESET = 1'b0;
    exp_q.delete();
    tag_q.delete();
    step(32'hC000_0000, 5'd8, 1'b0, 1'b0, 32'hFFC0_0000, "post_rst_asr");
    step(32'h0000_00FF, 5'd8, 1'b1, 1'b0, 32'h0000_FF00, "post_rst_shl");
    for (int i = 1; i < LAT; i++) step(32'h0, 5'd0, 1'b0, 1'b0, 32'h0, "flush");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
